// File: rtl/brcomp_pipe.sv
// Pipelined branch comparator: registered less/equal flags, taken decision and mispredict flag.
// Define BRCOMP_STATS_EN to add saturating branch and mispredict counters on the output stage.
module brcomp_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter bit SPLIT_COMPARE = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  br_unsigned_i,
    input  logic                  is_branch_i,
    input  logic [2:0]            funct3_i,
    input  logic                  pred_taken_i,
    output logic                  valid_o,
    output logic                  br_less_o,
    output logic                  br_equal_o,
    output logic                  br_taken_o,
    output logic                  mispred_o
`ifdef BRCOMP_STATS_EN
    ,
    output logic [31:0]           br_count_o,
    output logic [31:0]           mispred_count_o
`endif
);

    localparam int H = DATA_WIDTH / 2;

    function automatic logic decode_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:  decode_taken = eq;
            3'b001:  decode_taken = !eq;
            3'b100:  decode_taken = lt;
            3'b101:  decode_taken = !lt;
            3'b110:  decode_taken = lt;
            3'b111:  decode_taken = !lt;
            default: decode_taken = 1'b0;
        endcase
    endfunction

    // Inputs to the final register stage, produced by whichever front end is built.
    logic       nxt_valid;
    logic       nxt_eq;
    logic       nxt_lt;
    logic [2:0] nxt_funct3;
    logic       nxt_branch;
    logic       nxt_pred;

    generate
        if (SPLIT_COMPARE) begin : g_split
            logic [H-1:0] a_hi, b_hi, a_lo, b_lo;
            logic         hi_lt_c;
            logic         s1_valid, s1_hi_eq, s1_hi_lt, s1_lo_eq, s1_lo_lt;
            logic         s1_branch, s1_pred;
            logic [2:0]   s1_funct3;

            assign a_hi = rs1_data_i[DATA_WIDTH-1:H];
            assign b_hi = rs2_data_i[DATA_WIDTH-1:H];
            assign a_lo = rs1_data_i[H-1:0];
            assign b_lo = rs2_data_i[H-1:0];

            // Signed rule applies to the upper half only; the lower half is always magnitude.
            always_comb begin
                if (!br_unsigned_i && (a_hi[H-1] != b_hi[H-1])) hi_lt_c = a_hi[H-1];
                else                                            hi_lt_c = (a_hi < b_hi);
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_valid  <= 1'b0;
                    s1_hi_eq  <= 1'b0;
                    s1_hi_lt  <= 1'b0;
                    s1_lo_eq  <= 1'b0;
                    s1_lo_lt  <= 1'b0;
                    s1_branch <= 1'b0;
                    s1_pred   <= 1'b0;
                    s1_funct3 <= 3'b000;
                end else if (flush_i) begin
                    s1_valid  <= 1'b0;
                end else if (!stall_i) begin
                    s1_valid  <= valid_i;
                    s1_hi_eq  <= (a_hi == b_hi);
                    s1_hi_lt  <= hi_lt_c;
                    s1_lo_eq  <= (a_lo == b_lo);
                    s1_lo_lt  <= (a_lo < b_lo);
                    s1_branch <= is_branch_i;
                    s1_pred   <= pred_taken_i;
                    s1_funct3 <= funct3_i;
                end
            end

            assign nxt_valid  = s1_valid;
            assign nxt_eq     = s1_hi_eq & s1_lo_eq;
            assign nxt_lt     = s1_hi_lt | (s1_hi_eq & s1_lo_lt);
            assign nxt_funct3 = s1_funct3;
            assign nxt_branch = s1_branch;
            assign nxt_pred   = s1_pred;
        end else begin : g_single
            logic full_lt;

            // Same-sign words compare correctly as unsigned, including negative pairs.
            always_comb begin
                if (!br_unsigned_i && (rs1_data_i[DATA_WIDTH-1] != rs2_data_i[DATA_WIDTH-1]))
                    full_lt = rs1_data_i[DATA_WIDTH-1];
                else
                    full_lt = (rs1_data_i < rs2_data_i);
            end

            assign nxt_valid  = valid_i;
            assign nxt_eq     = (rs1_data_i == rs2_data_i);
            assign nxt_lt     = full_lt;
            assign nxt_funct3 = funct3_i;
            assign nxt_branch = is_branch_i;
            assign nxt_pred   = pred_taken_i;
        end
    endgenerate

    logic nxt_taken;
    logic out_valid, out_lt, out_eq, out_taken, out_mispred, out_branch;

    assign nxt_taken = nxt_branch & decode_taken(nxt_funct3, nxt_eq, nxt_lt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid   <= 1'b0;
            out_lt      <= 1'b0;
            out_eq      <= 1'b0;
            out_taken   <= 1'b0;
            out_mispred <= 1'b0;
            out_branch  <= 1'b0;
        end else if (flush_i) begin
            out_valid   <= 1'b0;
        end else if (!stall_i) begin
            out_valid   <= nxt_valid;
            out_lt      <= nxt_lt;
            out_eq      <= nxt_eq;
            out_taken   <= nxt_taken;
            out_mispred <= nxt_branch & (nxt_taken ^ nxt_pred);
            out_branch  <= nxt_branch;
        end
    end

    assign valid_o    = out_valid;
    assign br_less_o  = out_valid & out_lt;
    assign br_equal_o = out_valid & out_eq;
    assign br_taken_o = out_valid & out_taken;
    assign mispred_o  = out_valid & out_mispred;

`ifdef BRCOMP_STATS_EN
    logic [31:0] br_cnt, mis_cnt;

    // A result is counted on the edge where it leaves the output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt  <= 32'd0;
            mis_cnt <= 32'd0;
        end else if (!stall_i && out_valid && out_branch) begin
            if (br_cnt != 32'hFFFF_FFFF)                  br_cnt  <= br_cnt + 32'd1;
            if (out_mispred && mis_cnt != 32'hFFFF_FFFF) mis_cnt <= mis_cnt + 32'd1;
        end
    end

    assign br_count_o      = br_cnt;
    assign mispred_count_o = mis_cnt;
`endif

endmodule
